// File: rtl/booth_seq_ctrl.sv
// Control sequencer for a radix-2 Booth multiplier: drives the A/Q shift-register
// and accumulator strobes, tracks the Q-1 bit and iteration count, reports busy/done.
module booth_seq_ctrl #(
   parameter int NBITS = 8,
   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1
) (
   input  logic          clk1,
   input  logic          rstn,
   input  logic          start,
   input  logic          q0,
   output logic          ld_sel,
   output logic          reg_en,
   output logic          clr_acc,
   output logic [1:0]    alu_op,
   output logic          acc_we,
   output logic          qm1,
   output logic [CW-1:0] cnt,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   state_t state;
   state_t nxt;

   function automatic state_t next_state(input state_t s, input logic st, input logic q,
                                         input logic qm, input logic [CW-1:0] c);
      state_t n;
      n = IDLE;
      case (s)
         IDLE:    n = st ? LOAD : IDLE;
         LOAD:    n = EVAL;
         EVAL: begin
            case ({q, qm})
               2'b10:   n = SUB;
               2'b01:   n = ADD;
               default: n = SHIFT;
            endcase
         end
         ADD:     n = SHIFT;
         SUB:     n = SHIFT;
         SHIFT:   n = (c == LAST) ? DONE : EVAL;
         DONE:    n = IDLE;
         default: n = IDLE;
      endcase
      return n;
   endfunction

   // Output vector: {ld_sel, reg_en, clr_acc, alu_op[1:0], acc_we, busy, done}
   function automatic logic [7:0] decode(input state_t s);
      logic [7:0] d;
      d = 8'b0000_0000;
      case (s)
         LOAD:    d = 8'b1110_0010;
         EVAL:    d = 8'b0000_0010;
         ADD:     d = 8'b0000_1110;
         SUB:     d = 8'b0001_0110;
         SHIFT:   d = 8'b0100_0010;
         DONE:    d = 8'b0000_0011;
         default: d = 8'b0000_0000;
      endcase
      return d;
   endfunction

   always_comb begin
      nxt = next_state(state, start, q0, qm1, cnt);
   end

   // Outputs are registered from the next-state decode, so they track the state
   // register exactly and have no combinational path from any input.
   always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         qm1     <= 1'b0;
         cnt     <= '0;
         ld_sel  <= 1'b0;
         reg_en  <= 1'b0;
         clr_acc <= 1'b0;
         alu_op  <= 2'b00;
         acc_we  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= nxt;
         {ld_sel, reg_en, clr_acc, alu_op, acc_we, busy, done} <= decode(nxt);
         case (state)
            LOAD: begin
               qm1 <= 1'b0;
               cnt <= '0;
            end
            SHIFT: begin
               qm1 <= q0;
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: models the A/Q/M datapath, checks done timing,
// product, acc_we count and strobe exclusivity through a scoreboard queue.
module tb_booth_seq_ctrl;

   localparam int NBITS = 8;
   localparam int CW = 3;

   logic          clk1 = 1'b0;
   logic          rstn;
   logic          start;
   logic          q0;
   logic          ld_sel, reg_en, clr_acc, acc_we, qm1, busy, done;
   logic [1:0]    alu_op;
   logic [CW-1:0] cnt;

   booth_seq_ctrl #(.NBITS(NBITS)) dut (
      .clk1(clk1), .rstn(rstn), .start(start), .q0(q0),
      .ld_sel(ld_sel), .reg_en(reg_en), .clr_acc(clr_acc), .alu_op(alu_op),
      .acc_we(acc_we), .qm1(qm1), .cnt(cnt), .busy(busy), .done(done)
   );

   always #5 clk1 = ~clk1;

   int n_pass = 0;
   int n_total = 0;
   int edge_cnt = 0;
   int ops_seen = 0;
   int done_cnt = 0;

   logic [7:0] mcand = 8'h00;
   logic [7:0] mplier = 8'h00;
   logic [7:0] a_reg = 8'h00;
   logic [7:0] q_reg = 8'h00;
   logic [11:0] outs;

   assign q0 = q_reg[0];
   assign outs = {ld_sel, reg_en, clr_acc, alu_op, acc_we, qm1, cnt, busy, done};

   typedef struct {
      int          done_at;
      logic [15:0] prod;
      int          ops;
   } sb_t;
   sb_t sb[$];
   sb_t cur;

   typedef struct {
      logic [7:0] mc;
      logic [7:0] mp;
      int         lat;
      int         ops;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic push(input int done_at, input logic [7:0] mc, input logic [7:0] mp,
                       input int ops);
      int a;
      int b;
      sb_t e;
      a = $signed(mc);
      b = $signed(mp);
      e.done_at = done_at;
      e.prod = 16'(a * b);
      e.ops = ops;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk1);
      chk("drain", sb.size(), 0);
      repeat (2) @(negedge clk1);
      chk("idle_busy", busy, 1'b0);
   endtask

   task automatic run_one(input logic [7:0] mc, input logic [7:0] mp, input int lat,
                          input int ops, input bit glitch);
      @(negedge clk1);
      mcand = mc;
      mplier = mp;
      start = 1'b1;
      push(edge_cnt + lat, mc, mp, ops);
      @(negedge clk1);
      start = 1'b0;
      if (glitch) begin
         repeat (5) @(negedge clk1);
         start = 1'b1;
         @(negedge clk1);
         start = 1'b0;
      end
      drain(80);
   endtask

   // Datapath model: A, Q registers with arithmetic right shift across A:Q
   always @(posedge clk1) begin
      edge_cnt <= edge_cnt + 1;
      if (reg_en && ld_sel) begin
         q_reg <= mplier;
         if (clr_acc) a_reg <= 8'h00;
      end else if (reg_en) begin
         {a_reg, q_reg} <= {a_reg[7], a_reg, q_reg[7:1]};
      end else if (acc_we) begin
         if (alu_op == 2'b01) a_reg <= a_reg + mcand;
         else if (alu_op == 2'b10) a_reg <= a_reg - mcand;
      end
   end

   always @(negedge clk1) begin
      chk("strobes", {26'd0,
                      done & reg_en,
                      done & ~busy,
                      (alu_op != 2'b00) != acc_we,
                      clr_acc & ~(ld_sel & reg_en),
                      alu_op == 2'b11,
                      reg_en & acc_we}, 32'd0);
      if (clr_acc) ops_seen = 0;
      else if (acc_we) ops_seen++;
      if (done) begin
         done_cnt++;
         chk("sb_pending", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("done_time", edge_cnt, cur.done_at);
            chk("product", {a_reg, q_reg}, cur.prod);
            chk("cnt_at_done", cnt, NBITS - 1);
            chk("acc_we_count", ops_seen, cur.ops);
         end
      end
   end

   initial begin
      bit found;
      int t;
      int d0;

      tbl[0] = '{mc: 8'h5A, mp: 8'h00, lat: 18, ops: 0};
      tbl[1] = '{mc: 8'h13, mp: 8'hFF, lat: 19, ops: 1};
      tbl[2] = '{mc: 8'h03, mp: 8'h55, lat: 26, ops: 8};
      tbl[3] = '{mc: 8'h7F, mp: 8'h80, lat: 19, ops: 1};
      tbl[4] = '{mc: 8'hF6, mp: 8'h3C, lat: 20, ops: 2};

      rstn = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk1);
      chk("reset_outs", outs, 12'd0);
      rstn = 1'b1;

      // Abort in the middle of a SUB cycle
      @(negedge clk1);
      mcand = 8'h03;
      mplier = 8'h55;
      start = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk1);
         if (alu_op == 2'b10) found = 1'b1;
      end
      chk("reach_sub", found, 1'b1);
      #2 rstn = 1'b0;
      #1 chk("abort_outs", outs, 12'd0);
      @(negedge clk1);
      rstn = 1'b1;

      for (int i = 0; i < 5; i++) run_one(tbl[i].mc, tbl[i].mp, tbl[i].lat, tbl[i].ops, 1'b0);

      // start pulsed while busy must be ignored
      d0 = done_cnt;
      run_one(8'h03, 8'h55, 26, 8, 1'b1);
      repeat (30) @(negedge clk1);
      chk("single_done", done_cnt - d0, 1);

      // start held high: three back-to-back runs with one IDLE between each
      @(negedge clk1);
      mcand = 8'h7F;
      mplier = 8'h80;
      start = 1'b1;
      t = edge_cnt;
      push(t + 19, 8'h7F, 8'h80, 1);
      push(t + 19 + 20, 8'h7F, 8'h80, 1);
      push(t + 19 + 40, 8'h7F, 8'h80, 1);
      for (int i = 0; i < 100 && edge_cnt < t + 41; i++) @(negedge clk1);
      start = 1'b0;
      drain(80);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: time %0t limit %0t", $time, 200000);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequencer for the 8-bit radix-2 Booth multiplier. It accepts a start request, drives the parallel-load/shift select and enables of the A/Q shift registers, and selects add/subtract/no-op for the accumulator from the current Booth bit pair. It keeps the Q-1 bit and the iteration counter internally. It reports busy/done to the host. It sits between the host handshake and the datapath of shift registers and the adder/subtractor.

## Interface
- NBITS, 8, number of Booth iterations (operand width); counter width is clog2(NBITS), minimum 1
- clk1  input  1  single system clock, all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- q0  input  1  current multiplier LSB from the Q shift register
- ld_sel  output  1  shift-register mode select: 1 = parallel load, 0 = shift
- reg_en  output  1  A/Q shift-register clock enable
- clr_acc  output  1  clear accumulator A to 0
- alu_op  output  2  00 none, 01 A+M, 10 A−M, 11 never driven
- acc_we  output  1  write adder result into A
- qm1  output  1  Booth Q-1 bit (observability)
- cnt  output  clog2(NBITS)  completed-shift count
- busy  output  1  high from LOAD through DONE inclusive
- done  output  1  one-cycle pulse; product valid in A:Q while high

## Operation
- Moore FSM with states IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE. All outputs are decoded from the state register only, so no combinational input-to-output paths exist.
- Reset (rstn=0, asynchronous):
  - state=IDLE, cnt=0, qm1=0
  - every output 0
- IDLE: all outputs 0. start=1 → LOAD.
- LOAD: ld_sel=1, reg_en=1, clr_acc=1. On exit, qm1←0 and cnt←0. Next state is EVAL.
- EVAL: all datapath strobes 0. Decode {q0,qm1}:
  - 10 → SUB
  - 01 → ADD
  - 00 or 11 → SHIFT
- ADD: alu_op=01, acc_we=1 → SHIFT.
- SUB: alu_op=10, acc_we=1 → SHIFT.
- SHIFT: ld_sel=0, reg_en=1 (arithmetic right shift of A:Q). On exit, qm1←q0 (sampled this cycle). Then:
  - if cnt==NBITS−1 → DONE, cnt holds
  - otherwise cnt←cnt+1 → EVAL
- DONE: done=1, reg_en=0 (A:Q frozen) → IDLE unconditionally.
- Strobe exclusivity: reg_en and acc_we are never both 1. clr_acc is 1 only in LOAD. alu_op≠00 only in ADD/SUB.
- start while busy is ignored and not queued. start held high through DONE starts a new operation only via IDLE, one cycle later.
- rstn asserted mid-operation aborts immediately to the reset state. The datapath contents are then don't-care.

## Timing
- start=1 sampled at edge k puts the FSM in LOAD during cycle k+1. busy rises in that same cycle.
- Each iteration takes 2 cycles (EVAL, SHIFT) or 3 cycles (EVAL, ADD/SUB, SHIFT).
- done is high in cycle k+2+2·NBITS+nops, where nops is the number of add/sub iterations:
  - NBITS=8 range is k+18 to k+26
  - busy falls the cycle after done
- Minimum start-to-start spacing is 2·NBITS+3 cycles: IDLE must be revisited.
- q0 must be stable at the rising edge ending EVAL and the edge ending SHIFT. The controller adds no extra latency on q0.

## Test plan
- Reset: drive rstn=0 mid-SUB at any cycle → all outputs 0 immediately (before the next clk1 edge), state IDLE. After release, a new start runs normally.
- Multiplier 0x00 (bench models the Q register): start at edge k → no ADD/SUB visited; 8 SHIFT cycles; done pulse in cycle k+18 only; cnt=7 at done.
- Multiplier 0xFF: first iteration SUB (pair 10), remaining 7 iterations no-op (pair 11) → exactly one acc_we pulse; done in cycle k+19.
- Multiplier 0x55: pairs alternate 10,01,... → SUB/ADD alternate 8 times; 8 acc_we pulses; done in cycle k+26.
- Handshake: pulse start again during busy → ignored, done exactly once. Hold start high continuously → back-to-back runs, each done separated by 2·8+3+nops cycles, with one IDLE cycle between runs.
- Full product check: 0x7F × 0x80 with the bench datapath model → A:Q = 0xC080 (−16256) at done. The strobe exclusivity assertions hold on every cycle.
